// File: rtl/serial_adder.sv
// ---------------------------------------------------------------------------
// serial_adder: bit-serial WIDTH-bit adder that reuses one 1-bit full adder
// (FA) for WIDTH cycles, LSB first. A start/busy/done handshake is provided.
// The completed result is held in registers until the next completion.
//
// Ports:
//   clk   - rising-edge clock
//   rst   - synchronous, active-high reset
//   start - request an addition (sampled only in IDLE)
//   a, b  - WIDTH-bit operands, captured on the accepting edge
//   cin   - carry-in, captured on the accepting edge
//   busy  - high while bits are being processed (SHIFT)
//   done  - one-cycle pulse; sum/cout are valid in this cycle
//   sum   - registered WIDTH-bit result
//   cout  - registered final carry
//
// FA: the shared 1-bit full adder cell.
// ---------------------------------------------------------------------------
module FA (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic S,
    output logic Cout
);
    assign S    = A ^ B ^ Cin;
    assign Cout = (A & B) | (Cin & (A ^ B));
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_sh_a;
    logic [WIDTH-1:0] r_sh_b;
    logic [WIDTH-1:0] r_work;
    logic [WIDTH-1:0] w_work_shift;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic             w_s;
    logic             w_cout;
    logic             w_last;

    FA u_fa (
        .A    (r_sh_a[0]),
        .B    (r_sh_b[0]),
        .Cin  (r_carry),
        .S    (w_s),
        .Cout (w_cout)
    );

    assign w_last = (r_cnt == CW'(WIDTH - 1));

    // Work register shifted right with the new sum bit entering at the MSB.
    // Written as a loop so that WIDTH=1 needs no zero-width slice.
    always_comb begin
        w_work_shift            = '0;
        w_work_shift[WIDTH-1]   = w_s;
        for (int unsigned i = 0; i + 1 < WIDTH; i++) begin
            w_work_shift[i] = r_work[i+1];
        end
    end

    // Next-state and state-decoded outputs
    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) w_state_nxt = SHIFT;
            end
            SHIFT: begin
                busy = 1'b1;
                if (w_last) w_state_nxt = DONE;
            end
            DONE: begin
                done        = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    // Datapath; result registers only update on the final SHIFT edge
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sh_a  <= '0;
            r_sh_b  <= '0;
            r_work  <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_sh_a  <= a;
                        r_sh_b  <= b;
                        r_carry <= cin;
                        r_cnt   <= '0;
                        r_work  <= '0;
                    end
                end
                SHIFT: begin
                    r_sh_a  <= r_sh_a >> 1;
                    r_sh_b  <= r_sh_b >> 1;
                    r_work  <= w_work_shift;
                    r_carry <= w_cout;
                    r_cnt   <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_sum  <= w_work_shift;
                        r_cout <= w_cout;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sum  = r_sum;
    assign cout = r_cout;
endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;
    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start, cin, busy, done, cout;
    logic [7:0] a, b, sum;

    logic       s1_start, s1_cin, s1_busy, s1_done, s1_cout;
    logic [0:0] s1_a, s1_b, s1_sum;

    int         n_pass  = 0;
    int         n_total = 0;
    logic [8:0] exp_prev;

    serial_adder #(.WIDTH(8)) u_dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout)
    );

    serial_adder #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(s1_start), .a(s1_a), .b(s1_b), .cin(s1_cin),
        .busy(s1_busy), .done(s1_done), .sum(s1_sum), .cout(s1_cout)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One addition on the 8-bit DUT; expectation is plain integer arithmetic.
    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_, input logic tc,
                          input string tag);
        logic [8:0] expv;
        int         busy_n;
        bit         seen;
        bit         stable;
        expv = 9'(ta) + 9'(tb_) + 9'(tc);
        @(negedge clk);
        a = ta; b = tb_; cin = tc; start = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        busy_n = 0;
        seen   = 0;
        stable = 1;
        for (int k = 0; k < 20 && !seen; k++) begin
            if (k > 0) @(negedge clk);
            if (done) begin
                seen = 1;
                chk($sformatf("%s_busy_at_done", tag), 32'(busy), 32'd0);
            end else if (busy) begin
                busy_n++;
                stable &= ({cout, sum} === exp_prev);
                a   = 8'($urandom);
                b   = 8'($urandom);
                cin = 1'($urandom);
            end
        end
        chk($sformatf("%s_done_seen", tag), 32'(seen), 32'd1);
        chk($sformatf("%s_busy_cycles", tag), 32'(busy_n), 32'd8);
        chk($sformatf("%s_hold_prev", tag), 32'(stable), 32'd1);
        chk($sformatf("%s_result", tag), 32'({cout, sum}), 32'(expv));
        @(negedge clk);
        chk($sformatf("%s_done_width", tag), 32'(done), 32'd0);
        chk($sformatf("%s_busy_after", tag), 32'(busy), 32'd0);
        exp_prev = expv;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1);
    end

    initial begin
        int ndone;
        int last_t;
        int dn;
        bit stable;

        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        s1_start = 1'b0; s1_a = '0; s1_b = '0; s1_cin = 1'b0;
        exp_prev = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_w1", 32'({s1_busy, s1_done, s1_sum, s1_cout}), 32'd0);
        rst = 1'b0;

        // Directed cases
        run_op(8'h0F, 8'h01, 1'b0, "d0f01");
        run_op(8'hFF, 8'h01, 1'b0, "dff01");
        run_op(8'h00, 8'h00, 1'b1, "d0000c");

        // start held high: back-to-back operations every WIDTH+2 cycles
        @(negedge clk);
        a = 8'hA5; b = 8'h5A; cin = 1'b1; start = 1'b1;
        ndone  = 0;
        last_t = -1;
        stable = 1;
        for (int t = 0; t < 40 && ndone < 3; t++) begin
            @(negedge clk);
            if (done) begin
                chk("held_result", 32'({cout, sum}), 32'h100);
                chk("held_busy_at_done", 32'(busy), 32'd0);
                if (last_t >= 0) chk("held_spacing", 32'(t - last_t), 32'd10);
                last_t = t;
                ndone++;
                if (ndone == 3) start = 1'b0;
            end
            if (busy) begin
                if (ndone > 0) stable &= ({cout, sum} === 9'h100);
                a   = 8'($urandom);
                b   = 8'($urandom);
                cin = 1'($urandom);
            end else begin
                a = 8'hA5; b = 8'h5A; cin = 1'b1;
            end
        end
        start = 1'b0;
        chk("held_count", 32'(ndone), 32'd3);
        chk("held_stable", 32'(stable), 32'd1);
        exp_prev = 9'h100;
        repeat (2) @(negedge clk);

        // Reset four cycles into SHIFT aborts the operation
        a = 8'h33; b = 8'h44; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_sum", 32'(sum), 32'd0);
        chk("abort_cout", 32'(cout), 32'd0);
        dn = 0;
        for (int t = 0; t < 12; t++) begin
            @(negedge clk);
            if (done) dn++;
        end
        chk("abort_no_done", 32'(dn), 32'd0);
        exp_prev = '0;
        run_op(8'h33, 8'h44, 1'b0, "post_rst");

        // Random sweep, plus the extremes
        run_op(8'hFF, 8'hFF, 1'b1, "max");
        for (int i = 0; i < 200; i++) begin
            run_op(8'($urandom), 8'($urandom), 1'($urandom), "rand");
        end

        // WIDTH=1 build
        @(negedge clk);
        s1_a = 1'b1; s1_b = 1'b1; s1_cin = 1'b1; s1_start = 1'b1;
        @(negedge clk);
        s1_start = 1'b0; s1_a = 1'b0; s1_b = 1'b0; s1_cin = 1'b0;
        chk("w1_busy", 32'(s1_busy), 32'd1);
        chk("w1_done_early", 32'(s1_done), 32'd0);
        chk("w1_hold", 32'({s1_cout, s1_sum}), 32'd0);
        @(negedge clk);
        chk("w1_done", 32'(s1_done), 32'd1);
        chk("w1_busy_at_done", 32'(s1_busy), 32'd0);
        chk("w1_result", 32'({s1_cout, s1_sum}), 32'b11);
        @(negedge clk);
        chk("w1_done_width", 32'(s1_done), 32'd0);
        chk("w1_result_held", 32'({s1_cout, s1_sum}), 32'b11);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
